// File: rtl/ha_or_ripple_unit.sv
// Registered N-bit ALU built from half-adder and OR cells: ADD, HADD, OR, INC.
// Each ADD slice is HA(a,b) -> HA(t1,c) -> OR(t2,t3) into the next carry.
module ha_or_ripple_unit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             co
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_HADD = 2'b01,
    OP_OR   = 2'b10,
    OP_INC  = 2'b11
  } op_e;

  // Returns {carry, sum}.
  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  function automatic logic or2(input logic x, input logic y);
    return x | y;
  endfunction

  logic [WIDTH-1:0] s_add, s_hadd, s_or, s_inc;
  logic             c_add, c_inc, hc_any;
  logic             t1, t2, t3;

  logic [WIDTH-1:0] s_d, s_q;
  logic             co_d, co_q;
  logic             valid_d, valid_q;

  always_comb begin
    s_add  = '0;
    s_hadd = '0;
    s_or   = '0;
    s_inc  = '0;
    c_add  = ci;
    c_inc  = ci;
    hc_any = 1'b0;
    t1     = 1'b0;
    t2     = 1'b0;
    t3     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      {t2, t1}               = ha(a[i], b[i]);
      {t3, s_add[i]}         = ha(t1, c_add);
      c_add                  = or2(t2, t3);
      s_hadd[i]              = t1;
      hc_any                 = or2(hc_any, t2);
      s_or[i]                = or2(a[i], b[i]);
      {c_inc, s_inc[i]}      = ha(a[i], c_inc);
    end
  end

  always_comb begin
    s_d     = s_q;
    co_d    = co_q;
    valid_d = in_valid;
    if (in_valid) begin
      case (op_e'(op))
        OP_ADD:  begin s_d = s_add;  co_d = c_add;  end
        OP_HADD: begin s_d = s_hadd; co_d = hc_any; end
        OP_OR:   begin s_d = s_or;   co_d = 1'b0;   end
        default: begin s_d = s_inc;  co_d = c_inc;  end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q     <= '0;
      co_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      s_q     <= s_d;
      co_q    <= co_d;
      valid_q <= valid_d;
    end
  end

  assign s         = s_q;
  assign co        = co_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_ha_or_ripple_unit.sv
// Self-checking bench: directed vector table, WIDTH=1 full-adder sweep,
// randomized ops against an arithmetic reference model, and reset/hold sequences.
module tb_ha_or_ripple_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a, b;
  logic       ci;
  logic       out_valid;
  logic [7:0] s;
  logic       co;

  logic       in_valid1;
  logic [0:0] a1, b1, s1;
  logic       ci1, out_valid1, co1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_s;
  logic       m_co;

  always #5 clk = ~clk;

  ha_or_ripple_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .a(a), .b(b),
    .ci(ci), .out_valid(out_valid), .s(s), .co(co)
  );

  ha_or_ripple_unit #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .op(2'b00), .a(a1), .b(b1),
    .ci(ci1), .out_valid(out_valid1), .s(s1), .co(co1)
  );

  typedef struct {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] es;
    logic       eco;
  } vec_t;

  vec_t vecs[11];

  // Returns {co, s} packed as co at bit w, computed from the operation rules.
  function automatic longint unsigned ref_model(input int w, input logic [1:0] o,
                                                input longint unsigned ia,
                                                input longint unsigned ib,
                                                input logic ic);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint unsigned x = ia & m;
    longint unsigned y = ib & m;
    case (o)
      2'b00:   return (x + y + 64'(ic)) & ((m << 1) | 64'd1);
      2'b01:   return (64'(((x & y) != 0)) << w) | (x ^ y);
      2'b10:   return x | y;
      default: return x + 64'(ic);
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step8(input logic v, input logic [1:0] o, input logic [7:0] ia,
                       input logic [7:0] ib, input logic ic, input logic [7:0] es,
                       input logic eco, input logic ev, input string name);
    @(negedge clk);
    in_valid = v; op = o; a = ia; b = ib; ci = ic;
    @(posedge clk);
    #1;
    check({name, ".s"}, 64'(s), 64'(es));
    check({name, ".co"}, 64'(co), 64'(eco));
    check({name, ".out_valid"}, 64'(out_valid), 64'(ev));
  endtask

  initial begin
    longint unsigned r;
    logic       v;
    logic [1:0] o;
    logic [7:0] ia, ib;
    logic       ic;
    logic [1:0] fa;

    vecs[0]  = '{2'b00, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1]  = '{2'b00, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2]  = '{2'b00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3]  = '{2'b00, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4]  = '{2'b01, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b1};
    vecs[5]  = '{2'b10, 8'hF0, 8'h3C, 1'b1, 8'hFC, 1'b0};
    vecs[6]  = '{2'b01, 8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b0};
    vecs[7]  = '{2'b01, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b0};
    vecs[8]  = '{2'b11, 8'hFF, 8'hAA, 1'b1, 8'h00, 1'b1};
    vecs[9]  = '{2'b11, 8'h7F, 8'h55, 1'b1, 8'h80, 1'b0};
    vecs[10] = '{2'b11, 8'h12, 8'hFF, 1'b0, 8'h12, 1'b0};

    rst_n = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0; ci = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;

    // Async reset between edges: no clock edge before t=5.
    #2 rst_n = 1'b0;
    #1;
    check("rst_async.s", 64'(s), 64'h0);
    check("rst_async.co", 64'(co), 64'h0);
    check("rst_async.out_valid", 64'(out_valid), 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    step8(1'b0, 2'b00, 8'hAB, 8'hCD, 1'b1, 8'h00, 1'b0, 1'b0, "idle0");
    step8(1'b0, 2'b00, 8'hAB, 8'hCD, 1'b1, 8'h00, 1'b0, 1'b0, "idle1");

    for (int k = 0; k < 11; k++)
      step8(1'b1, vecs[k].op, vecs[k].a, vecs[k].b, vecs[k].ci,
            vecs[k].es, vecs[k].eco, 1'b1, $sformatf("vec%0d", k));

    step8(1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, "b2b_1");
    step8(1'b1, 2'b00, 8'h02, 8'h02, 1'b0, 8'h04, 1'b0, 1'b1, "b2b_2");
    step8(1'b0, 2'b01, 8'hFF, 8'hFF, 1'b1, 8'h04, 1'b0, 1'b0, "hold_1");
    step8(1'b0, 2'b00, 8'hFF, 8'hFF, 1'b1, 8'h04, 1'b0, 1'b0, "hold_2");

    // WIDTH=1 full-adder truth table.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      in_valid1 = 1'b1;
      a1 = 1'(k >> 2); b1 = 1'(k >> 1); ci1 = 1'(k);
      fa = 2'(k >> 2 & 1) + 2'(k >> 1 & 1) + 2'(k & 1);
      @(posedge clk);
      #1;
      check($sformatf("w1_%0d.s", k), 64'(s1), 64'(fa[0]));
      check($sformatf("w1_%0d.co", k), 64'(co1), 64'(fa[1]));
      check($sformatf("w1_%0d.out_valid", k), 64'(out_valid1), 64'h1);
    end
    @(negedge clk) in_valid1 = 1'b0;

    m_s = 8'h04; m_co = 1'b0;
    for (int k = 0; k < 300; k++) begin
      v  = ($urandom_range(0, 3) != 0);
      o  = 2'($urandom_range(0, 3));
      ia = 8'($urandom);
      ib = 8'($urandom);
      ic = 1'($urandom);
      if (v) begin
        r = ref_model(8, o, 64'(ia), 64'(ib), ic);
        m_s  = r[7:0];
        m_co = r[8];
      end
      step8(v, o, ia, ib, ic, m_s, m_co, v, $sformatf("rnd%0d", k));
    end

    step8(1'b1, 2'b00, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b1, "pre_rst");
    @(negedge clk);
    in_valid = 1'b1; op = 2'b00; a = 8'h33; b = 8'h44; ci = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.s", 64'(s), 64'h0);
    check("rst_mid.co", 64'(co), 64'h0);
    check("rst_mid.out_valid", 64'(out_valid), 64'h0);
    @(posedge clk);
    #1;
    check("rst_held.s", 64'(s), 64'h0);
    check("rst_held.out_valid", 64'(out_valid), 64'h0);
    @(negedge clk) rst_n = 1'b1;
    step8(1'b1, 2'b00, 8'hFE, 8'h01, 1'b1, 8'h00, 1'b1, 1'b1, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ha_or_ripple_unit.md
# ha_or_ripple_unit

Registered N-bit arithmetic/logic unit built from half-adder and 2-input OR cells. Each bit slice is two half adders plus an OR for carry-out, chained as a ripple-carry adder. The unit adds, half-adds, ORs or increments two operands and registers the result once per accepted input. It is the datapath leaf used wherever the design needs a small registered adder built from the standard half-adder/OR cell library.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  operands and op are valid this cycle
- op  input  2  operation select: 00 ADD, 01 HADD, 10 OR, 11 INC
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B (ignored by INC)
- ci  input  1  carry-in into bit 0 (ADD and INC only)
- out_valid  output  1  s/co hold a result produced by the previous accepted input
- s  output  WIDTH  registered result
- co  output  1  registered carry/flag

## Operation
- Cell definitions:
  - Half adder: sum = x^y, carry = x&y.
  - OR cell: z = x|y.
- Bit slice i, where c0 = ci:
  - HA(a_i, b_i) gives t1, t2.
  - HA(t1, c_i) gives s_i, t3.
  - OR(t2, t3) gives c_{i+1}.
  - The final carry c_WIDTH is the adder's carry-out.
- ADD (00): {co,s} = a + b + ci, computed modulo 2^(WIDTH+1).
- HADD (01): s = a ^ b bitwise; co = OR-reduction of (a & b), i.e. 1 if any bit-level half-adder carry is set.
- OR (10): s = a | b; co = 0.
- INC (11): half-adder chain only. c0 = ci; s_i = a_i ^ c_i; c_{i+1} = a_i & c_i; co = c_WIDTH. Equivalent to {co,s} = a + ci.
- ci is ignored for HADD and OR.
- Combinational path from inputs to register D contains no state. Only s, co and out_valid are registered.

## Timing
- Reset (rst_n=0): s=0, co=0 and out_valid=0 immediately, with no clock required. They stay 0 while rst_n is low.
- Reset release: the first rising edge with rst_n=1 may capture.
- Latency is one cycle. On a rising edge with in_valid=1, s and co load the result of the current a/b/ci/op, and out_valid becomes 1.
- On a rising edge with in_valid=0: out_valid becomes 0 and s/co hold their previous values.
- Throughput is one operation per cycle. There is no backpressure; consecutive valid cycles each produce a result on the following cycle.
- Reset asserted mid-stream discards any in-flight result. Outputs return to 0 asynchronously.
- Carry ripples through all WIDTH slices within one clock period. There is no internal pipelining.

## Test plan
- Reset: drive rst_n=0 between clock edges → s=0x00, co=0, out_valid=0 without waiting for an edge; release, then in_valid=0 for 2 cycles → outputs stay 0.
- ADD, WIDTH=8:
  - a=0x5A, b=0x3C, ci=0 → next cycle s=0x96, co=0, out_valid=1.
  - a=0xFF, b=0x00, ci=1 → s=0x00, co=1.
  - a=0xFF, b=0xFF, ci=1 → s=0xFF, co=1.
- HADD/OR, a=0xF0, b=0x3C:
  - HADD → s=0xCC, co=1.
  - OR → s=0xFC, co=0.
  - HADD with a=0x0F, b=0xF0 → s=0xFF, co=0.
- INC:
  - a=0xFF, ci=1, b=0xAA → s=0x00, co=1.
  - a=0x7F, ci=1 → s=0x80, co=0.
  - a=0x12, ci=0 → s=0x12, co=0.
- WIDTH=1 exhaustive ADD: all 8 {a,b,ci} → full-adder truth table, e.g. 001 → s=1,co=0; 011 → s=0,co=1; 111 → s=1,co=1.
- Hold and reset mid-stream:
  - Back-to-back valid ADDs (1+1, then 2+2) → s=0x02 then 0x04 on consecutive cycles.
  - Then in_valid=0 → s holds 0x04, out_valid=0.
  - Assert rst_n=0 during a valid cycle → s=0, co=0, out_valid=0 at once.
